ram_refresh: RTL and testbench
==============================

RAM_REFRESH -- requirements
Module: ram_refresh

Interface
REQ-001 Parameter RAS_CYC, default 3: CLK cycles nRAS is held low per refresh; legal range 1..7.
REQ-002 Parameter PRE_CYC, default 2: CLK cycles of RAS/CAS precharge after release; legal range 1..7.
REQ-003 CLK  in  1  FSB clock; single clock domain, all logic on the rising edge.
REQ-004 RST  in  1  reset; synchronous, active-high.
REQ-005 RefReq  in  1  refresh period level from the refresh timer; low for one E period marks the period boundary.
REQ-006 RefUrg  in  1  refresh urgent; the current period is near its end.
REQ-007 BACT  in  1  FSB RAM access in progress.
REQ-008 RAMCS  in  1  RAM select for a new FSB access this cycle.
REQ-009 nRAS  out  1  DRAM RAS for refresh; active-low; registered.
REQ-010 nCAS  out  1  DRAM CAS for refresh; active-low; registered.
REQ-011 RefAct  out  1  refresh cycle owns the RAM bus (address/strobe mux select); registered.
REQ-012 RAMHold  out  1  block the start of new FSB RAM accesses; registered.
REQ-013 RefMiss  out  8  count of refresh periods that ended without a completed refresh.

Function
REQ-014 RefReqr (RefReq delayed one CLK) drives edge detection; RefFall = RefReqr && !RefReq.
REQ-015 RefDone flag: cleared in any cycle RefReq==0; set when the sequencer leaves PRE while RefReq==1.
REQ-016 Pending = RefReq && !RefDone.
REQ-017 States: IDLE, CAS, RAS, PRE. State encoding is a package enum.
REQ-018 IDLE->CAS when Pending && !BACT && !RAMCS; otherwise remain in IDLE.
REQ-019 When RAMCS and a non-urgent Pending coincide, the FSB access wins and refresh does not start.
REQ-020 CAS: nCAS=0, nRAS=1, RefAct=1 for exactly 1 cycle, then go to RAS.
REQ-021 RAS: nCAS=0, nRAS=0 for RAS_CYC cycles (3-bit down-counter), then go to PRE.
REQ-022 PRE: nCAS=1, nRAS=1, RefAct=1 for PRE_CYC cycles, then go to IDLE.
REQ-023 Output timing: nCAS falls 1 CLK after the start condition is sampled; with defaults RefAct is high for 6 consecutive cycles.
REQ-024 RAMHold is registered from (Pending && RefUrg) || (state!=IDLE).
REQ-025 Under urgency, the sequencer still waits in IDLE for BACT==0; RAMCS is ignored while RAMHold==1.
REQ-026 If RefReq falls mid-sequence, the sequence completes normally and RefDone stays 0.
REQ-027 A refresh started in the RefReq==0 window does not satisfy the next period.
REQ-028 RefFall && !RefDone counts as a miss (see Configuration).
REQ-029 At most one refresh sequence per RefReq period.

Reset
REQ-030 On RST: state=IDLE, nRAS=1, nCAS=1, RefAct=0, RAMHold=0, RefDone=0, RefReqr=0, counters=0, RefMiss=0.
REQ-031 RST asserted mid-sequence aborts immediately; strobes are high on the next edge.

Configuration
REQ-032 Macro REF_MISS_CNT_EN defined: RefMiss is an 8-bit counter incremented on each miss, saturating at 8'hFF; it is cleared only by RST.
REQ-033 Macro REF_MISS_CNT_EN undefined: RefMiss is tied to 0 and no counter logic is generated; all other behaviour is identical.

Structure
REQ-034 Package ram_pkg holds the refresh state enum typedef and the RAS_CYC/PRE_CYC defaults.
REQ-035 Sub-module ref_miss_cnt implements the 8-bit saturating counter; it is instantiated only under REF_MISS_CNT_EN.

Verification
REQ-036 Idle bus with RefReq 0->1 and BACT=RAMCS=0 -> nCAS low at +1 CLK, nRAS low +2..+4, both high +5, RefAct high +1..+6, RefDone set.
REQ-037 RefReq held high through a completed refresh -> no second sequence; nRAS/nCAS stay high until RefReq 0->1.
REQ-038 RefUrg=1 with BACT=1 for 10 cycles -> RAMHold=1 the next cycle; RAMCS pulses are ignored; refresh starts 1 CLK after BACT falls.
REQ-039 RefReq falls before any refresh, REF_MISS_CNT_EN defined -> RefMiss 0->1; 300 misses -> saturates at 8'hFF. Macro undefined -> RefMiss=0.
REQ-040 RST pulsed during RAS state -> next edge nRAS=nCAS=1, RefAct=0, RAMHold=0, RefMiss=0, state IDLE.
REQ-041 RAMCS=1 in the same cycle Pending rises, RefUrg=0 -> no refresh start that cycle; refresh starts after BACT drops and RAMCS=0.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg -- shared types and defaults for the DRAM refresh sequencer.
//   ref_state_e  : refresh sequencer state encoding
//   RAS_CYC_DEF  : default nRAS low time in CLK cycles
//   PRE_CYC_DEF  : default precharge time in CLK cycles
package ram_pkg;

  localparam int RAS_CYC_DEF = 3;
  localparam int PRE_CYC_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAS  = 2'd1,
    ST_RAS  = 2'd2,
    ST_PRE  = 2'd3
  } ref_state_e;

endpackage

// File: rtl/ram_refresh_if.sv
// ram_refresh_if -- refresh-timer / FSB handshake and DRAM strobe bundle.
//   RefReq, RefUrg  : refresh period level and urgency from the refresh timer
//   BACT, RAMCS     : FSB RAM access in progress / new access select
//   nRAS, nCAS      : active-low refresh strobes
//   RefAct          : refresh owns the RAM address/strobe mux
//   RAMHold         : blocks the start of new FSB RAM accesses
//   RefMiss         : count of refresh periods that ended unserviced
// Modports: master = the refresh controller, slave = its environment.
interface ram_refresh_if;
  logic       RefReq;
  logic       RefUrg;
  logic       BACT;
  logic       RAMCS;
  logic       nRAS;
  logic       nCAS;
  logic       RefAct;
  logic       RAMHold;
  logic [7:0] RefMiss;

  modport master (
    input  RefReq, RefUrg, BACT, RAMCS,
    output nRAS, nCAS, RefAct, RAMHold, RefMiss
  );

  modport slave (
    output RefReq, RefUrg, BACT, RAMCS,
    input  nRAS, nCAS, RefAct, RAMHold, RefMiss
  );
endinterface

// File: rtl/ref_miss_cnt.sv
// ref_miss_cnt -- 8-bit saturating counter of missed refresh periods.
//   CLK   : clock, rising edge
//   RST   : synchronous active-high reset (the only way to clear the count)
//   inc_i : one-cycle pulse, a refresh period ended without a refresh
//   cnt_o : current count, sticks at 8'hFF
module ref_miss_cnt (
  input  logic       CLK,
  input  logic       RST,
  input  logic       inc_i,
  output logic [7:0] cnt_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ram_refresh.sv
// ram_refresh -- CAS-before-RAS DRAM refresh sequencer with FSB arbitration.
//   CLK  : FSB clock, all logic on the rising edge
//   RST  : synchronous active-high reset
//   bus  : ram_refresh_if.master (RefReq/RefUrg/BACT/RAMCS in;
//          nRAS/nCAS/RefAct/RAMHold/RefMiss out)
// Parameters: RAS_CYC (1..7) nRAS low cycles, PRE_CYC (1..7) precharge cycles.
// Build option: define REF_MISS_CNT_EN to generate the missed-refresh
// counter; otherwise RefMiss is tied to zero.
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | waiting for a pending refresh and a quiet FSB
// CAS   | nCAS low alone for one cycle (CAS-before-RAS)
// RAS   | nCAS and nRAS low for RAS_CYC cycles
// PRE   | both strobes high, bus still owned, PRE_CYC cycles
module ram_refresh
  import ram_pkg::*;
#(
  parameter int RAS_CYC = RAS_CYC_DEF,
  parameter int PRE_CYC = PRE_CYC_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  ram_refresh_if.master bus
);

  ref_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic       void_q, void_d;
  logic       nras_q, nras_d;
  logic       ncas_q, ncas_d;
  logic       act_q, act_d;
  logic       hold_q, hold_d;

  logic pending;
  logic start;
  logic seq_end;

  assign pending = bus.RefReq && !done_q;
  // Once RAMHold is up the FSB cannot legally start an access, so a RAMCS
  // seen then is stale and must not stall the refresh.
  assign start   = pending && !bus.BACT && (!bus.RAMCS || hold_q);
  assign seq_end = (state_q == ST_PRE) && (cnt_q == 3'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 3'd0;
        if (start) state_d = ST_CAS;
      end
      ST_CAS: begin
        state_d = ST_RAS;
        cnt_d   = 3'(RAS_CYC - 1);
      end
      ST_RAS: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_PRE;
          cnt_d   = 3'(PRE_CYC - 1);
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_PRE: begin
        if (cnt_q == 3'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes are registered from the next state so they line up with it.
    ncas_d = !((state_d == ST_CAS) || (state_d == ST_RAS));
    nras_d = (state_d != ST_RAS);
    act_d  = (state_d != ST_IDLE);
    hold_d = (pending && bus.RefUrg) || (state_q != ST_IDLE);

    // A sequence that saw RefReq low belongs to the old period; it must not
    // mark the new period as refreshed.
    void_d = void_q;
    if (state_q == ST_IDLE)  void_d = 1'b0;
    else if (!bus.RefReq)    void_d = 1'b1;

    done_d = done_q;
    if (!bus.RefReq)               done_d = 1'b0;
    else if (seq_end && !void_q)   done_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      void_q  <= 1'b0;
      nras_q  <= 1'b1;
      ncas_q  <= 1'b1;
      act_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      void_q  <= void_d;
      nras_q  <= nras_d;
      ncas_q  <= ncas_d;
      act_q   <= act_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.nRAS    = nras_q;
  assign bus.nCAS    = ncas_q;
  assign bus.RefAct  = act_q;
  assign bus.RAMHold = hold_q;

`ifdef REF_MISS_CNT_EN
  // RefReq edge detect only feeds the miss counter.
  logic ref_req_r_q;
  logic ref_fall;

  always_ff @(posedge CLK) begin
    if (RST) ref_req_r_q <= 1'b0;
    else     ref_req_r_q <= bus.RefReq;
  end

  assign ref_fall = ref_req_r_q && !bus.RefReq;

  ref_miss_cnt u_miss_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc_i (ref_fall && !done_q),
    .cnt_o (bus.RefMiss)
  );
`else
  assign bus.RefMiss = 8'h00;
`endif

endmodule

// File: tb/tb_ram_refresh.sv
module tb_ram_refresh;
  localparam int RC      = 3;
  localparam int PC      = 2;
  localparam int SEQ_LEN = 1 + RC + PC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_refresh_if bus_if ();

  ram_refresh #(.RAS_CYC(RC), .PRE_CYC(PC)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus_if)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a refresh is a fixed timeline of SEQ_LEN cycles counted
  // from its start; age k is the k-th cycle after the start was sampled.
  int m_age;
  bit m_prev_req, m_done, m_void, m_hold;
  int m_miss;

  task automatic model_reset();
    m_age = 0; m_prev_req = 0; m_done = 0; m_void = 0; m_hold = 0; m_miss = 0;
  endtask

  task automatic step(input bit r, input bit u, input bit b, input bit c, input bit rs);
    bit pending, busy, start, last, fall;
    int age_n;
    logic [7:0] exp_miss;
    @(negedge clk);
    rst = rs;
    bus_if.RefReq = r; bus_if.RefUrg = u; bus_if.BACT = b; bus_if.RAMCS = c;
    if (rs) begin
      model_reset();
    end else begin
      pending = r && !m_done;
      busy    = (m_age != 0);
      fall    = m_prev_req && !r;
      start   = !busy && pending && !b && (!c || m_hold);
      last    = (m_age == SEQ_LEN);
      if (fall && !m_done && m_miss < 255) m_miss++;
      if (!r) m_done = 0;
      else if (last && !m_void) m_done = 1;
      if (start) m_void = 0;
      else if (busy && !r) m_void = 1;
      m_hold = (pending && u) || busy;
      age_n = start ? 1 : ((busy && !last) ? m_age + 1 : 0);
      m_age = age_n;
      m_prev_req = r;
    end
`ifdef REF_MISS_CNT_EN
    exp_miss = 8'(m_miss);
`else
    exp_miss = 8'h00;
`endif
    @(posedge clk);
    #1;
    chk("nCAS",    {7'd0, bus_if.nCAS},    {7'd0, !(m_age >= 1 && m_age <= 1 + RC)});
    chk("nRAS",    {7'd0, bus_if.nRAS},    {7'd0, !(m_age >= 2 && m_age <= 1 + RC)});
    chk("RefAct",  {7'd0, bus_if.RefAct},  {7'd0, (m_age >= 1 && m_age <= SEQ_LEN)});
    chk("RAMHold", {7'd0, bus_if.RAMHold}, {7'd0, m_hold});
    chk("RefMiss", bus_if.RefMiss, exp_miss);
  endtask

  initial begin
    bit r;
    int len;
    bus_if.RefReq = 0; bus_if.RefUrg = 0; bus_if.BACT = 0; bus_if.RAMCS = 0;
    model_reset();

    repeat (3) step(0, 0, 0, 0, 1);
    // Idle bus, RefReq rises: one full refresh, then none while held high.
    repeat (2) step(0, 0, 0, 0, 0);
    repeat (20) step(1, 0, 0, 0, 0);
    chk("one_refresh_done", {7'd0, bus_if.nRAS}, 8'd1);
    // Period ends unserviced (BACT busy): a miss.
    step(0, 0, 0, 0, 0);
    repeat (4) step(1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    // Urgent with BACT busy for 10 cycles and RAMCS pulses.
    for (int i = 0; i < 10; i++) step(1, 1, 1, i[0], 0);
    repeat (10) step(1, 1, 0, 1, 0);
    // RAMCS coincident with non-urgent pending, then BACT holds, then clears.
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    repeat (3) step(1, 0, 1, 0, 0);
    repeat (10) step(1, 0, 0, 0, 0);
    // RefReq drops mid-sequence and comes back during precharge.
    step(0, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    repeat (14) step(1, 0, 0, 0, 0);
    // Reset pulsed while in RAS.
    step(0, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    chk("rst_nCAS", {7'd0, bus_if.nCAS}, 8'd1);
    chk("rst_RefAct", {7'd0, bus_if.RefAct}, 8'd0);
    repeat (10) step(1, 0, 0, 0, 0);

    // Randomized periods.
    r = 1;
    for (int p = 0; p < 150; p++) begin
      len = r ? $urandom_range(3, 30) : $urandom_range(1, 4);
      for (int k = 0; k < len; k++)
        step(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));
      r = !r;
    end

    // 300 unserviced periods: miss counter saturation.
    for (int p = 0; p < 300; p++) begin
      step(1, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
    end
`ifdef REF_MISS_CNT_EN
    chk("miss_sat", bus_if.RefMiss, 8'hFF);
`else
    chk("miss_off", bus_if.RefMiss, 8'h00);
`endif
    step(0, 0, 0, 0, 1);
    chk("miss_rst", bus_if.RefMiss, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
